// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, a one-entry hold buffer
// for responses that land during a stall, and branch redirect with response discard.
//
// state | meaning
// IDLE  | no request outstanding; may issue when the hold buffer is empty
// WAIT  | one request outstanding, its response is wanted
// DROP  | one request outstanding, its response will be discarded
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Branch,
   input  logic [31:0] BranchTarget,
   input  logic        Stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] IF_ID_PC,
   output logic [31:0] IF_ID_Instr,
   output logic        IF_ID_Valid
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_req_pc;
   logic        r_hold_valid;
   logic [31:0] r_hold_pc;
   logic [31:0] r_hold_instr;

   logic        w_hs;
   logic        w_redirect;
   logic        w_resp;
   logic [31:0] w_target;

   assign imem_req   = (r_state == S_IDLE) && !r_hold_valid;
   assign imem_addr  = r_pc;
   assign w_hs       = imem_req && imem_gnt;
   assign w_redirect = Branch && !Stall && IF_ID_Valid;
   assign w_resp     = (r_state == S_WAIT) && imem_rvalid;
   assign w_target   = BranchTarget & 32'hFFFF_FFFC;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_pc         <= RESET_PC;
         r_req_pc     <= 32'h0;
         r_hold_valid <= 1'b0;
         r_hold_pc    <= 32'h0;
         r_hold_instr <= NOP;
         IF_ID_PC     <= 32'h0;
         IF_ID_Instr  <= NOP;
         IF_ID_Valid  <= 1'b0;
      end else begin
         if (w_redirect)
            r_pc <= w_target;
         else if (w_hs)
            r_pc <= r_pc + 32'd4;

         if (w_hs)
            r_req_pc <= r_pc;

         case (r_state)
            S_IDLE: if (w_hs) r_state <= w_redirect ? S_DROP : S_WAIT;
            S_WAIT: begin
               if (imem_rvalid)
                  r_state <= S_IDLE;
               else if (w_redirect)
                  r_state <= S_DROP;
            end
            S_DROP: if (imem_rvalid) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase

         // A stalled response parks in the hold buffer; it drains once Stall drops.
         if (w_redirect) begin
            r_hold_valid <= 1'b0;
         end else if (w_resp && Stall) begin
            r_hold_valid <= 1'b1;
            r_hold_pc    <= r_req_pc;
            r_hold_instr <= imem_rdata;
         end else if (!Stall) begin
            r_hold_valid <= 1'b0;
         end

         if (w_redirect) begin
            IF_ID_Valid <= 1'b0;
         end else if (!Stall) begin
            if (w_resp) begin
               IF_ID_PC    <= r_req_pc;
               IF_ID_Instr <= imem_rdata;
               IF_ID_Valid <= 1'b1;
            end else if (r_hold_valid) begin
               IF_ID_PC    <= r_hold_pc;
               IF_ID_Instr <= r_hold_instr;
               IF_ID_Valid <= 1'b1;
            end else begin
               IF_ID_Valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle vector table plus hand-written
// sequences for PC wrap and asynchronous mid-operation reset.
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] D   = 32'h1000_0000;

   logic        clk;
   logic        rst_n;
   logic        br;
   logic [31:0] tgt;
   logic        stall;
   logic        gnt;
   logic        rv;
   logic [31:0] rdata;
   logic        req;
   logic [31:0] addr;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_v;

   logic        w_gnt;
   logic        w_rv;
   logic [31:0] w_rdata;
   logic        w_req;
   logic [31:0] w_addr;
   logic [31:0] w_id_pc;
   logic [31:0] w_id_instr;
   logic        w_id_v;

   int n_cmp = 0;
   int n_err = 0;

   if_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .Branch(br), .BranchTarget(tgt), .Stall(stall),
      .imem_req(req), .imem_addr(addr), .imem_gnt(gnt), .imem_rvalid(rv),
      .imem_rdata(rdata), .IF_ID_PC(id_pc), .IF_ID_Instr(id_instr), .IF_ID_Valid(id_v)
   );

   if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .Branch(1'b0), .BranchTarget(32'h0), .Stall(1'b0),
      .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt), .imem_rvalid(w_rv),
      .imem_rdata(w_rdata), .IF_ID_PC(w_id_pc), .IF_ID_Instr(w_id_instr), .IF_ID_Valid(w_id_v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        br;
      logic [31:0] tgt;
      logic        stall;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_v;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic b, input logic [31:0] t, input logic s, input logic g,
                      input logic r, input logic [31:0] rd, input logic eq,
                      input logic [31:0] ea, input logic ev, input logic [31:0] ep,
                      input logic [31:0] ei);
      vec_t v;
      v.br = b; v.tgt = t; v.stall = s; v.gnt = g; v.rv = r; v.rdata = rd;
      v.e_req = eq; v.e_addr = ea; v.e_v = ev; v.e_pc = ep; v.e_instr = ei;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; br = 1'b0; tgt = 32'h0; stall = 1'b0; gnt = 1'b0; rv = 1'b0; rdata = 32'h0;
      w_gnt = 1'b0; w_rv = 1'b0; w_rdata = 32'h0;

      //   br tgt       st g  rv rdata      req addr      v  pc        instr
      add(0, 32'h0,   0, 1, 0, 32'h0,    1, 32'h0,    0, 32'h0,   NOP);
      add(0, 32'h0,   0, 1, 1, D+32'h0,  0, 32'h4,    1, 32'h0,   D+32'h0);
      add(0, 32'h0,   0, 1, 0, 32'h0,    1, 32'h4,    0, 32'h0,   D+32'h0);
      add(0, 32'h0,   0, 1, 1, D+32'h4,  0, 32'h8,    1, 32'h4,   D+32'h4);
      add(0, 32'h0,   1, 1, 0, 32'h0,    1, 32'h8,    1, 32'h4,   D+32'h4);
      add(0, 32'h0,   1, 1, 1, D+32'h8,  0, 32'hC,    1, 32'h4,   D+32'h4);
      add(0, 32'h0,   1, 1, 0, 32'h0,    0, 32'hC,    1, 32'h4,   D+32'h4);
      add(0, 32'h0,   0, 1, 0, 32'h0,    0, 32'hC,    1, 32'h8,   D+32'h8);
      add(0, 32'h0,   0, 1, 0, 32'h0,    1, 32'hC,    0, 32'h8,   D+32'h8);
      add(0, 32'h0,   0, 1, 1, D+32'hC,  0, 32'h10,   1, 32'hC,   D+32'hC);
      add(0, 32'h0,   1, 1, 0, 32'h0,    1, 32'h10,   1, 32'hC,   D+32'hC);
      add(1, 32'h100, 0, 1, 0, 32'h0,    0, 32'h14,   0, 32'hC,   D+32'hC);
      add(0, 32'h0,   0, 1, 1, D+32'h10, 0, 32'h100,  0, 32'hC,   D+32'hC);
      add(0, 32'h0,   0, 0, 0, 32'h0,    1, 32'h100,  0, 32'hC,   D+32'hC);
      add(0, 32'h0,   0, 1, 0, 32'h0,    1, 32'h100,  0, 32'hC,   D+32'hC);
      add(0, 32'h0,   0, 1, 0, 32'h0,    0, 32'h104,  0, 32'hC,   D+32'hC);
      add(0, 32'h0,   0, 1, 1, D+32'h100,0, 32'h104,  1, 32'h100, D+32'h100);
      add(1, 32'h203, 0, 1, 0, 32'h0,    1, 32'h104,  0, 32'h100, D+32'h100);
      add(0, 32'h0,   0, 1, 0, 32'h0,    0, 32'h200,  0, 32'h100, D+32'h100);
      add(0, 32'h0,   0, 1, 1, D+32'h104,0, 32'h200,  0, 32'h100, D+32'h100);
      add(0, 32'h0,   0, 1, 0, 32'h0,    1, 32'h200,  0, 32'h100, D+32'h100);
      add(0, 32'h0,   0, 1, 1, D+32'h200,0, 32'h204,  1, 32'h200, D+32'h200);
      add(1, 32'h400, 1, 1, 0, 32'h0,    1, 32'h204,  1, 32'h200, D+32'h200);
      add(0, 32'h0,   0, 1, 1, D+32'h204,0, 32'h208,  1, 32'h204, D+32'h204);
      add(0, 32'h0,   1, 1, 0, 32'h0,    1, 32'h208,  1, 32'h204, D+32'h204);
      add(1, 32'h300, 0, 0, 1, D+32'h208,0, 32'h20C,  0, 32'h204, D+32'h204);
      add(0, 32'h0,   0, 0, 0, 32'h0,    1, 32'h300,  0, 32'h204, D+32'h204);

      // Reset values while rst_n is held low
      @(negedge clk); @(negedge clk);
      chk("rst_req",   {31'h0, req}, 32'h1);
      chk("rst_addr",  addr,         32'h0);
      chk("rst_valid", {31'h0, id_v}, 32'h0);
      chk("rst_pc",    id_pc,        32'h0);
      chk("rst_instr", id_instr,     NOP);
      chk("rst_waddr", w_addr,       32'hFFFF_FFFC);

      // Wrap: fetch at 0xFFFF_FFFC, next request goes to 0
      rst_n = 1'b1;
      w_gnt = 1'b1;
      #1;
      chk("wrap_req0",  {31'h0, w_req}, 32'h1);
      chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      w_gnt = 1'b0; w_rv = 1'b1; w_rdata = 32'hCAFE_0001;
      #1;
      chk("wrap_req_wait", {31'h0, w_req}, 32'h0);
      chk("wrap_pc_next",  w_addr, 32'h0);
      @(posedge clk); #1;
      chk("wrap_id_v",  {31'h0, w_id_v}, 32'h1);
      chk("wrap_id_pc", w_id_pc, 32'hFFFF_FFFC);
      chk("wrap_id_in", w_id_instr, 32'hCAFE_0001);
      @(negedge clk);
      w_rv = 1'b0;
      #1;
      chk("wrap_req1",  {31'h0, w_req}, 32'h1);
      chk("wrap_addr1", w_addr, 32'h0);

      // Per-cycle vector table on the main instance
      foreach (tbl[i]) begin
         @(negedge clk);
         br = tbl[i].br; tgt = tbl[i].tgt; stall = tbl[i].stall;
         gnt = tbl[i].gnt; rv = tbl[i].rv; rdata = tbl[i].rdata;
         #1;
         chk($sformatf("v%0d_req", i),  {31'h0, req}, {31'h0, tbl[i].e_req});
         chk($sformatf("v%0d_addr", i), addr, tbl[i].e_addr);
         @(posedge clk); #1;
         chk($sformatf("v%0d_valid", i), {31'h0, id_v}, {31'h0, tbl[i].e_v});
         chk($sformatf("v%0d_pc", i),    id_pc, tbl[i].e_pc);
         chk($sformatf("v%0d_instr", i), id_instr, tbl[i].e_instr);
      end

      // Asynchronous reset while a request is outstanding
      @(negedge clk);
      br = 1'b0; stall = 1'b0; gnt = 1'b1; rv = 1'b0;
      @(posedge clk);
      @(negedge clk);
      gnt = 1'b0;
      #1;
      chk("mid_pre_req",  {31'h0, req}, 32'h0);
      chk("mid_pre_addr", addr, 32'h304);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req",   {31'h0, req}, 32'h1);
      chk("mid_rst_addr",  addr, 32'h0);
      chk("mid_rst_valid", {31'h0, id_v}, 32'h0);
      chk("mid_rst_pc",    id_pc, 32'h0);
      chk("mid_rst_instr", id_instr, NOP);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
